// File: rtl/ps_pkg.sv
// Shared constants and types for the paralelo_serial byte-to-serial transmitter.
package ps_pkg;

  localparam logic [7:0]  PS_COMMA  = 8'hBC;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic {
    PREAMBLE = 1'b0,
    RUN      = 1'b1
  } ps_state_e;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = '1;

endpackage

// File: rtl/ps_hold_buf.sv
// One-entry holding register between the valid/ready input and the shift register.
module ps_hold_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              accept_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              full_q, full_d;

  // Accept wins over drain so a same-edge drain+accept leaves the entry full.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (drain_i) begin
      full_d = 1'b0;
    end
    if (accept_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter: comma preamble after reset, then MSB-first data with comma fill.
// Optional macro PS_TXCNT_EN adds tx_count_out (count of data bytes loaded for transmission).
module paralelo_serial
  import ps_pkg::*;
#(
  parameter int unsigned COMMA_PREAMBLE = 4,
  parameter logic [7:0]  COMMA          = PS_COMMA
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
  output logic        byte_start_out,
  output logic        active_out
`ifdef PS_TXCNT_EN
  ,
  output logic [15:0] tx_count_out
`endif
);

  localparam int unsigned     CNT_W    = $clog2(COMMA_PREAMBLE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COMMA_PREAMBLE - 1);

  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           cur_q, cur_d;
  logic [CNT_W-1:0]     comma_cnt_q, comma_cnt_d;
  ps_state_e            state_q, state_d;
  logic                 data_out_q, data_out_d;
  logic                 byte_start_q, byte_start_d;
  logic                 active_q, active_d;
`ifdef PS_TXCNT_EN
  logic [15:0]          tx_count_q, tx_count_d;
`endif

  logic       at_boundary;
  logic       ready;
  logic       accept;
  logic       drain;
  logic [7:0] hold_data;
  logic       hold_full;

  always_comb begin
    at_boundary = (bit_idx_q == LAST_BIT);
    ready       = (state_q == RUN) && (!hold_full || at_boundary);
    accept      = valid_in && ready;
    drain       = (state_q == RUN) && at_boundary && hold_full;
  end

  ps_hold_buf #(
    .DATA_W (8)
  ) u_hold (
    .clk      (clk_32f),
    .reset_L  (reset_L),
    .accept_i (accept),
    .drain_i  (drain),
    .data_i   (data_in),
    .data_o   (hold_data),
    .full_o   (hold_full)
  );

  always_comb begin
    bit_idx_d    = bit_idx_q + BIT_IDX_W'(1);
    data_out_d   = cur_q[LAST_BIT - bit_idx_q];
    byte_start_d = (bit_idx_q == '0);
    cur_d        = cur_q;
    comma_cnt_d  = comma_cnt_q;
    state_d      = state_q;
    active_d     = active_q;
`ifdef PS_TXCNT_EN
    tx_count_d   = tx_count_q;
`endif
    if (at_boundary) begin
      unique case (state_q)
        PREAMBLE: begin
          cur_d       = COMMA;
          comma_cnt_d = comma_cnt_q + CNT_W'(1);
          if (comma_cnt_q == LAST_CNT) begin
            state_d  = RUN;
            active_d = 1'b1;
          end
        end
        RUN: begin
          if (hold_full) begin
            cur_d = hold_data;
`ifdef PS_TXCNT_EN
            tx_count_d = tx_count_q + 16'd1;
`endif
          end else begin
            cur_d = COMMA;
          end
        end
        default: cur_d = COMMA;
      endcase
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      bit_idx_q    <= '0;
      cur_q        <= COMMA;
      comma_cnt_q  <= '0;
      state_q      <= PREAMBLE;
      data_out_q   <= 1'b0;
      byte_start_q <= 1'b0;
      active_q     <= 1'b0;
`ifdef PS_TXCNT_EN
      tx_count_q   <= '0;
`endif
    end else begin
      bit_idx_q    <= bit_idx_d;
      cur_q        <= cur_d;
      comma_cnt_q  <= comma_cnt_d;
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      byte_start_q <= byte_start_d;
      active_q     <= active_d;
`ifdef PS_TXCNT_EN
      tx_count_q   <= tx_count_d;
`endif
    end
  end

  assign ready_out      = ready;
  assign data_out       = data_out_q;
  assign byte_start_out = byte_start_q;
  assign active_out     = active_q;
`ifdef PS_TXCNT_EN
  assign tx_count_out   = tx_count_q;
`endif

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial: vector table, idle-stream checks and a byte scoreboard.
module tb_paralelo_serial;

  logic        clk_32f = 1'b0;
  logic        reset_L;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out;
  logic        byte_start_out;
  logic        active_out;
`ifdef PS_TXCNT_EN
  logic [15:0] tx_count_out;
`endif

  paralelo_serial #(
    .COMMA_PREAMBLE (4),
    .COMMA          (8'hBC)
  ) dut (
    .clk_32f        (clk_32f),
    .reset_L        (reset_L),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .data_out       (data_out),
    .byte_start_out (byte_start_out),
    .active_out     (active_out)
`ifdef PS_TXCNT_EN
    ,
    .tx_count_out   (tx_count_out)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       exp_do;
    logic       exp_bs;
    logic       exp_act;
    logic       exp_rdy;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned msb_edge;
  } exp_t;

  logic [7:0]  comma_b = 8'hBC;
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned k = 0;          // rising edges since reset release
  int unsigned data_seen = 0;  // non-comma bytes observed on the line
  exp_t        exp_q[$];
  exp_t        e;
  logic [7:0]  sh;
  int unsigned nbits = 0;
  int unsigned start_edge = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, k);
  endtask

  // Line monitor: frames bytes on byte_start_out and scores every non-comma byte.
  always @(posedge clk_32f) begin
    #2;
    if (!reset_L) begin
      k     = 0;
      nbits = 0;
    end else begin
      k++;
      if (byte_start_out === 1'b1) begin
        sh         = {7'b0, data_out};
        nbits      = 1;
        start_edge = k;
      end else if (nbits != 0) begin
        sh = {sh[6:0], data_out};
        nbits++;
      end
      if (nbits == 8) begin
        nbits = 0;
        if (sh !== comma_b) begin
          data_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'b0, sh}, {24'b0, comma_b});
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", {24'b0, sh}, {24'b0, e.data});
            chk("sb_msb_edge", start_edge, e.msb_edge);
          end
        end
      end
    end
  end

  task automatic wait_cycles(input int unsigned c);
    repeat (c) @(negedge clk_32f);
  endtask

  // Idle line from the current edge up to edge 'upto': comma stream, preamble flags.
  task automatic idle_check(input int unsigned upto, input string tag);
    for (int i = 0; i < 200 && k < upto; i++) begin
      @(negedge clk_32f);
      chk({tag, "_data_out"}, {31'b0, data_out}, {31'b0, comma_b[7 - ((k - 1) % 8)]});
      chk({tag, "_byte_start"}, {31'b0, byte_start_out}, {31'b0, (k % 8) == 1});
      chk({tag, "_active"}, {31'b0, active_out}, {31'b0, k >= 32});
      chk({tag, "_ready"}, {31'b0, ready_out}, {31'b0, k >= 32});
    end
    chk({tag, "_edges_reached"}, {31'b0, k >= upto}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d, output int unsigned n);
    bit          done;
    int unsigned b;
    done     = 1'b0;
    n        = 0;
    data_in  = d;
    valid_in = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ready_out === 1'b1) begin
        n = k + 1;
        b = k % 8;
        exp_q.push_back('{d, n + ((b == 7) ? 8 : (7 - b)) + 1});
        done = 1'b1;
      end
      @(negedge clk_32f);
    end
    valid_in = 1'b0;
    chk("send_handshake", {31'b0, done}, 32'd1);
  endtask

  initial begin
    vec_t        tbl[12];
    int unsigned tn[4];
    int unsigned n;
    logic [7:0]  vals[4];
    bit          hit;

    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset and the first post-reset edges, with valid_in pulses the preamble must ignore.
    @(negedge clk_32f);
    for (int i = 0; i < 12; i++) begin
      reset_L  = tbl[i].rst_n;
      valid_in = tbl[i].valid;
      data_in  = tbl[i].data;
      @(negedge clk_32f);
      chk($sformatf("vec%0d_data_out", i),   {31'b0, data_out},       {31'b0, tbl[i].exp_do});
      chk($sformatf("vec%0d_byte_start", i), {31'b0, byte_start_out}, {31'b0, tbl[i].exp_bs});
      chk($sformatf("vec%0d_active", i),     {31'b0, active_out},     {31'b0, tbl[i].exp_act});
      chk($sformatf("vec%0d_ready", i),      {31'b0, ready_out},      {31'b0, tbl[i].exp_rdy});
    end
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Idle through preamble and into RUN: pure comma stream.
    idle_check(64, "t1");

    // Single byte between commas.
    send(8'hA5, n);
    wait_cycles(24);
    chk("t2_queue_empty", exp_q.size(), 32'd0);
    chk("t2_data_count", data_seen, 32'd1);

    // Back-to-back bytes: one transfer per 8 edges, no comma in between.
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'hFF; vals[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], tn[i]);
      data_in  = vals[(i + 1) % 4];
      valid_in = (i < 3);
    end
    valid_in = 1'b0;
    chk("t3_xfer_gap_2", tn[2] - tn[1], 32'd8);
    chk("t3_xfer_gap_3", tn[3] - tn[2], 32'd8);
    wait_cycles(40);
    chk("t3_queue_empty", exp_q.size(), 32'd0);
    chk("t3_data_count", data_seen, 32'd5);

    // valid_in held while hold is full: ready low until the boundary.
    for (int i = 0; i < 8 && (k % 8) != 1; i++) @(negedge clk_32f);
    send(8'h5A, n);
    data_in  = 8'hC3;
    valid_in = 1'b1;
    hit      = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      if ((k % 8) == 7) begin
        chk("t4_ready_boundary", {31'b0, ready_out}, 32'd1);
        exp_q.push_back('{8'hC3, k + 1 + 8 + 1});
        hit = 1'b1;
      end else begin
        chk("t4_ready_full", {31'b0, ready_out}, 32'd0);
      end
      @(negedge clk_32f);
    end
    valid_in = 1'b0;
    wait_cycles(24);
    chk("t4_queue_empty", exp_q.size(), 32'd0);
    chk("t4_data_count", data_seen, 32'd7);

    // Reset mid-byte with 8'h3C in flight and 8'h77 held: both must vanish.
    send(8'h3C, n);
    send(8'h77, n);
    wait_cycles(3);
    reset_L = 1'b0;
    exp_q.delete();
    @(negedge clk_32f);
    chk("t5_rst_data_out",   {31'b0, data_out},       32'd0);
    chk("t5_rst_byte_start", {31'b0, byte_start_out}, 32'd0);
    chk("t5_rst_active",     {31'b0, active_out},     32'd0);
    chk("t5_rst_ready",      {31'b0, ready_out},      32'd0);
    reset_L = 1'b1;
    idle_check(64, "t5");
    wait_cycles(24);
    chk("t5_data_count", data_seen, 32'd7);

`ifdef PS_TXCNT_EN
    chk("t6_cnt_after_preamble", {16'b0, tx_count_out}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(8'h10 + 8'(i), n);
      wait_cycles(20);
    end
    wait_cycles(24);
    chk("t6_tx_count", {16'b0, tx_count_out}, 32'd5);
    chk("t6_data_count", data_seen, 32'd12);
`endif

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
